binary_gray: RTL and testbench



---
 rtl/binary_gray.sv | 64 ++++++
 tb/tb_binary_gray.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/binary_gray.sv
// binary_gray: registered dual-direction binary <-> reflected Gray converter.
// sel=0 converts binary to Gray, sel=1 converts Gray to binary; the result,
// a valid strobe and the producing sel appear one clock after sampling.
module binary_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] num,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_sel
);

  logic [WIDTH-1:0] w_b2g;
  logic [WIDTH-1:0] w_g2b;
  logic [WIDTH-1:0] w_conv;

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_sel;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
  always_comb begin
    w_b2g = num ^ (num >> 1);
  end

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i,
  // written as a reduction over the shifted word instead of a ripple chain.
  always_comb begin
    w_g2b = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_g2b[i] = ^(num >> i);
    end
  end

  // Direction select for the value about to be registered.
  always_comb begin
    w_conv = sel ? w_g2b : w_b2g;
  end

  // Output register: reset wins, accepted inputs load, otherwise hold data
  // and drop the valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
    end else if (in_valid) begin
      r_out   <= w_conv;
      r_sel   <= sel;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_binary_gray.sv
// Testbench for binary_gray: directed cases plus randomized traffic on a
// 4-bit and an 8-bit instance, checked against a behavioural model.
module tb_binary_gray;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] num4;
  logic       sel4, iv4;
  logic [3:0] out4;
  logic       ov4, os4;

  logic [7:0] num8;
  logic       sel8, iv8;
  logic [7:0] out8;
  logic       ov8, os8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  binary_gray #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .num(num4), .sel(sel4), .in_valid(iv4),
    .out(out4), .out_valid(ov4), .out_sel(os4)
  );

  binary_gray #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .num(num8), .sel(sel8), .in_valid(iv8),
    .out(out8), .out_valid(ov8), .out_sel(os8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray code of a binary value.
  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse Gray by search: the unique w-bit value whose Gray code equals g.
  function automatic logic [31:0] from_gray(input logic [31:0] g, input int unsigned w);
    for (int unsigned v = 0; v < (32'd1 << w); v++) begin
      if (to_gray(v) == g) return v;
    end
    return 32'hFFFF_FFFF;
  endfunction

  logic [31:0] m4_out, m8_out;
  logic        m4_v, m4_s, m8_v, m8_s;
  logic [3:0]  g;

  initial begin
    reset = 1'b1; iv4 = 1'b0; sel4 = 1'b0; num4 = '0;
    iv8 = 1'b0; sel8 = 1'b0; num8 = '0;
    tick(); tick();
    check("rst_out4", {28'd0, out4}, 32'd0);
    check("rst_v4", {31'd0, ov4}, 32'd0);
    check("rst_s4", {31'd0, os4}, 32'd0);
    check("rst_out8", {24'd0, out8}, 32'd0);
    reset = 1'b0;

    // Directed conversions.
    iv4 = 1'b1; sel4 = 1'b0; num4 = 4'b0101; tick();
    check("b2g_0101", {28'd0, out4}, 32'b0111);
    check("b2g_sel", {31'd0, os4}, 32'd0);
    check("b2g_v", {31'd0, ov4}, 32'd1);
    num4 = 4'b0001; tick();
    check("b2g_0001", {28'd0, out4}, 32'b0001);
    sel4 = 1'b1; num4 = 4'b1001; tick();
    check("g2b_1001", {28'd0, out4}, 32'b1110);
    check("g2b_sel", {31'd0, os4}, 32'd1);
    num4 = 4'b1000; tick();
    check("g2b_1000", {28'd0, out4}, 32'b1111);

    // Exhaustive round trip through the DUT.
    for (int unsigned v = 0; v < 16; v++) begin
      sel4 = 1'b0; num4 = v[3:0]; tick();
      check("rt_fwd", {28'd0, out4}, to_gray(v));
      g = out4;
      sel4 = 1'b1; num4 = g; tick();
      check("rt_back", {28'd0, out4}, v);
    end

    // Back-to-back alternating sel.
    sel4 = 1'b0; num4 = 4'b0101; tick();
    check("bb0", {28'd0, out4}, 32'b0111);
    check("bb0_v", {31'd0, ov4}, 32'd1);
    sel4 = 1'b1; num4 = 4'b1001; tick();
    check("bb1", {28'd0, out4}, 32'b1110);
    check("bb1_v", {31'd0, ov4}, 32'd1);
    sel4 = 1'b0; num4 = 4'b1111; tick();
    check("bb2", {28'd0, out4}, 32'b1000);
    check("bb2_v", {31'd0, ov4}, 32'd1);
    iv4 = 1'b0; tick();
    check("bb_drop_v", {31'd0, ov4}, 32'd0);
    check("bb_drop_out", {28'd0, out4}, 32'b1000);

    // Hold while idle.
    iv4 = 1'b1; sel4 = 1'b0; num4 = 4'b0101; tick();
    check("hold_load", {28'd0, out4}, 32'b0111);
    iv4 = 1'b0; sel4 = 1'b1; num4 = 4'b1010;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("hold_out", {28'd0, out4}, 32'b0111);
      check("hold_v", {31'd0, ov4}, 32'd0);
      check("hold_s", {31'd0, os4}, 32'd0);
    end

    // Reset beats a simultaneous valid input.
    iv4 = 1'b1; sel4 = 1'b1; num4 = 4'b1111; tick();
    reset = 1'b1; tick();
    check("rstp_out", {28'd0, out4}, 32'd0);
    check("rstp_v", {31'd0, ov4}, 32'd0);
    check("rstp_s", {31'd0, os4}, 32'd0);
    reset = 1'b0; iv4 = 1'b0; tick();

    // 8-bit instance.
    iv8 = 1'b1; sel8 = 1'b0; num8 = 8'b1011_0110; tick();
    check("w8_b2g", {24'd0, out8}, 32'b1110_1101);
    sel8 = 1'b1; num8 = 8'b1110_1101; tick();
    check("w8_g2b", {24'd0, out8}, 32'b1011_0110);
    check("w8_sel", {31'd0, os8}, 32'd1);
    iv8 = 1'b0; tick();
    check("w8_drop_v", {31'd0, ov8}, 32'd0);

    // Randomized traffic against the model.
    m4_out = {28'd0, out4}; m4_v = 1'b0; m4_s = os4;
    m8_out = {24'd0, out8}; m8_v = 1'b0; m8_s = os8;
    for (int unsigned c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 19) == 0);
      iv4 = $urandom_range(0, 3) != 0; sel4 = $urandom_range(0, 1) == 1; num4 = 4'($urandom);
      iv8 = $urandom_range(0, 3) != 0; sel8 = $urandom_range(0, 1) == 1; num8 = 8'($urandom);
      if (reset) begin
        m4_out = 0; m4_v = 0; m4_s = 0;
        m8_out = 0; m8_v = 0; m8_s = 0;
      end else begin
        m4_v = iv4;
        if (iv4) begin
          m4_out = sel4 ? from_gray({28'd0, num4}, 4) : to_gray({28'd0, num4});
          m4_s = sel4;
        end
        m8_v = iv8;
        if (iv8) begin
          m8_out = sel8 ? from_gray({24'd0, num8}, 8) : to_gray({24'd0, num8});
          m8_s = sel8;
        end
      end
      tick();
      check("rnd_out4", {28'd0, out4}, m4_out);
      check("rnd_v4", {31'd0, ov4}, {31'd0, m4_v});
      check("rnd_s4", {31'd0, os4}, {31'd0, m4_s});
      check("rnd_out8", {24'd0, out8}, m8_out);
      check("rnd_v8", {31'd0, ov8}, {31'd0, m8_v});
      check("rnd_s8", {31'd0, os8}, {31'd0, m8_s});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
